iob_cls_arb: RTL

Shared count-leading-signs (CLS) normalization service for the pt-float datapath. Up to N_REQ requesters (posit/float decode and normalize stages) submit two's-complement words over valid/ready. A round-robin arbiter grants one request at a time to a single combinational CLS core. The block returns the redundant-sign-bit count, the left-normalized word and the requester ID over a result valid/ready channel.

---
 rtl/iob_cls_arb_pkg.sv | 19 +
 rtl/iob_cls_core.sv | 25 ++
 rtl/iob_rr_arb.sv | 36 +++
 rtl/iob_cls_arb.sv | 110 +++++++++++
 4 files changed

// File: rtl/iob_cls_arb_pkg.sv
// Shared definitions for the CLS normalization service: FSM encodings and
// width helpers used by the top level and the round-robin arbiter.
package iob_cls_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/iob_cls_core.sv
// Combinational count-leading-signs core: number of bits below the MSB that
// match the MSB before the first differing bit (DATA_W-1 for all-0/all-1).
module iob_cls_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o
);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int i = DATA_W - 2; i >= 0; i--) begin
      if (run && (data_i[i] == data_i[DATA_W-1])) begin
        count_o = count_o + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/iob_rr_arb.sv
// Round-robin picker: first valid requester at or above ptr_i (mod N_REQ).
// Grant is one-hot when enabled and a request exists, otherwise zero.
module iob_rr_arb
  import iob_cls_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             found_o
);

  // Walk the offsets from farthest to nearest so the nearest valid wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_i[(int'(ptr_i) + k) % N_REQ]) begin
        found_o = 1'b1;
        idx_o   = ID_W'((int'(ptr_i) + k) % N_REQ);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_o[gi] = en_i && found_o && (idx_o == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/iob_cls_arb.sv
// Shared CLS normalization service: round-robin accept, one-cycle CLS and
// shift into registered result outputs, held until the result is taken.
module iob_cls_arb
  import iob_cls_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int ID_W   = id_width(N_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  output logic [N_REQ-1:0]               req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]        req_data_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [ID_W-1:0]                res_id_o,
  output logic [cnt_width(DATA_W)-1:0]   res_count_o,
  output logic [DATA_W-1:0]              res_data_o,
  output logic                           busy_o
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   op_q;
  logic                res_valid_q;
  logic [ID_W-1:0]     res_id_q;
  logic [CNT_W-1:0]    res_count_q;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     win_idx;
  logic                win_found;
  logic [DATA_W-1:0]   win_data;
  logic [CNT_W-1:0]    cls_count;

  // Reset gates the enable so no ready bit is raised during the reset cycle.
  iob_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    ((state_q == ST_IDLE) && !rst_i),
    .grant_o (grant),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  iob_cls_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cls (
    .data_i  (op_q),
    .count_o (cls_count)
  );

  assign win_data   = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
  assign res_data_d = op_q << cls_count;

  always_comb begin
    ptr_d = '0;
    if (N_REQ > 1 && win_idx != ID_W'(N_REQ - 1)) begin
      ptr_d = win_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_count_q <= '0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            op_q    <= win_data;
            id_q    <= win_idx;
            ptr_q   <= ptr_d;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          res_count_q <= cls_count;
          res_data_q  <= res_data_d;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = grant;
  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_count_o = res_count_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
